pooling_ctrl: RTL
=================

# pooling_ctrl

Sequencer for the `Pooling` datapath. It accepts a valid/ready stream of 8-bit convolution results and drives the pooling unit's `En` / `convResult` inputs for exactly one group of `GROUP_LEN` samples at a time. After the pooling latency it captures `pooledPixels` into an output register and presents it on a valid/ready result port. It sits between the convolution engine and downstream pixel storage.

## Interface
- `GROUP_LEN`, default 8: accepted samples per pooling group (≥2).
- `POOL_LAT`, default 1: cycles from the `Pooling` edge that samples the last `En` until `pooledPixels` is stable (≥1).
- `DW`, default 8: sample and pixel width.
- `NPIX`, default 4: pooled pixels per group.
- Clock: `clk`, single clock, rising edge.
- Reset: `rst`, synchronous, active-high.
- `clk` input 1: clock.
- `rst` input 1: synchronous active-high reset.
- `in_valid` input 1: upstream sample valid.
- `in_ready` output 1: controller accepts a sample this cycle.
- `in_data` input DW: upstream convolution result.
- `En` output 1: enable to `Pooling`, registered.
- `convResult` output DW: sample to `Pooling`, registered.
- `pooledPixels` input NPIX×DW: `Pooling` result.
- `out_valid` output 1: result register holds an unconsumed group.
- `out_ready` input 1: downstream consumes the result.
- `out_pixels` output NPIX×DW: captured result.
- `busy` output 1: high when state ≠ FEED or the sample count ≠ 0.

## Operation
- Accept = `in_valid & in_ready`.
- Each accept:
  - `En` ← 1 and `convResult` ← `in_data` on the next edge.
  - No accept: `En` ← 0 and `convResult` holds its value.
  - `cnt` increments, range 0..`GROUP_LEN`-1.
- FSM states: FEED, DRAIN, HOLD. Reset state: FEED.
- FEED:
  - `in_ready`=1.
  - On the accept with `cnt`=`GROUP_LEN`-1: `cnt`←0, `dcnt`←`POOL_LAT`, go to DRAIN.
- DRAIN:
  - `in_ready`=0.
  - `dcnt` decrements each cycle.
  - In the cycle `dcnt`=0: `out_pixels`←`pooledPixels`, `out_valid`←1, go to HOLD.
- HOLD:
  - `out_valid`=1 and `out_pixels` are stable.
  - On `out_valid & out_ready`: `out_valid`←0 and go to FEED. The first new accept is possible in the next cycle.
- `in_data` is passed through unmodified. The controller performs no arithmetic on samples.
- `cnt` width is `$clog2(GROUP_LEN)`. `dcnt` width is `$clog2(POOL_LAT+1)`.
- Reset at any point:
  - `cnt`, `dcnt`, `En`, `out_valid` and `busy` go to 0.
  - `convResult` and `out_pixels` go to 0.
  - State goes to FEED.
  - A partial group is discarded.
- `in_valid` deasserted mid-group: `En` drops for those cycles and `cnt` holds. The group still ends after exactly `GROUP_LEN` accepts.

## Timing
- Reset values: `in_ready`=1 (FEED), `En`=0, `convResult`=0, `out_valid`=0, `out_pixels`=0, `busy`=0.
- Latency, with the last accept in cycle t:
  - `En` is high in cycle t+1.
  - DRAIN occupies cycles t+1 .. t+1+`POOL_LAT`.
  - Capture happens at the end of cycle t+1+`POOL_LAT`.
  - `out_valid` rises in cycle t+2+`POOL_LAT`.
- Valid/ready rules:
  - `out_valid` never drops without `out_ready`.
  - `out_pixels` does not change while `out_valid` is high.
  - `in_ready` does not depend combinationally on `in_valid`.
- Simultaneous events: an accept and an `out_ready` in the same cycle are legal only with the overlap feature enabled, and are handled independently.

## Configuration
- Macro: `POOL_CTRL_OVERLAP_EN`.
- Undefined:
  - `in_ready`=0 in DRAIN and HOLD.
  - Groups are strictly serialized.
- Defined:
  - In HOLD, `in_ready`=1 and the next group's samples may be accepted.
  - Exception: when `cnt`=`GROUP_LEN`-1 and `out_valid` is high and `out_ready` is 0 in that cycle, `in_ready`=0, so the last sample stalls until the result is consumed.
  - The last accept in HOLD (with `out_ready`=1 in the same cycle) clears `out_valid` and goes directly to DRAIN.
  - `in_ready`=0 in DRAIN in both builds.

## Test plan
- **Reset.** Assert `rst` for 2 cycles during a group. Required: all outputs at reset values in the cycle after release, and the next group needs the full 8 accepts.
- **Single group, continuous input.** 8 continuous accepts in cycles 0..7 with values 0x31, 0x84, 0x12, 0x7F, 0xA0, 0x05, 0xFF, 0x40; `POOL_LAT`=1; model `Pooling` as pairwise max. Required:
  - `En` high in cycles 1..8 with `convResult` equal to those values in order.
  - `in_ready` low in cycles 8..9.
  - `out_valid` high in cycle 10 with `out_pixels` = {0x84, 0x7F, 0xA0, 0xFF} for pixel index 0..3.
- **Gapped input.** Drop `in_valid` for 3 cycles after sample 4. Required: `En` low in exactly those 3 cycles, `cnt` holds, and `out_valid` rises 3 cycles later than in the previous scenario.
- **Back-pressure.** Hold `out_ready`=0 for 5 cycles after `out_valid` rises. Required: `out_pixels` stable, `in_ready`=0 (overlap off), and return to FEED the cycle after the `out_ready` handshake.
- **Overlap build (`POOL_CTRL_OVERLAP_EN` defined).** Keep `out_ready`=0 while 7 samples of the next group are accepted. Required: `in_ready`=0 on the 8th sample until `out_ready`=1, then an immediate transition to DRAIN in that same cycle.
- **Latency sweep.** Run with `POOL_LAT`=3. Required: capture 3 cycles after the `Pooling` edge that samples the last `En`, and `out_valid` rises in cycle t+5 after the last accept.

Source files
------------

// File: rtl/pooling_ctrl.sv
// Sequencer feeding one GROUP_LEN-sample group at a time into the Pooling unit and holding its result.
// Optional POOL_CTRL_OVERLAP_EN lets the next group stream in while the previous result waits in HOLD.
module pooling_ctrl #(
    parameter int GROUP_LEN = 8,
    parameter int POOL_LAT  = 1,
    parameter int DW        = 8,
    parameter int NPIX      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    output logic                 En,
    output logic [DW-1:0]        convResult,
    input  logic [NPIX*DW-1:0]   pooledPixels,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NPIX*DW-1:0]   out_pixels,
    output logic                 busy
);
    localparam int CW  = $clog2(GROUP_LEN);
    localparam int DCW = $clog2(POOL_LAT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(GROUP_LEN - 1);
    localparam logic [DCW-1:0] DCNT_INIT = DCW'(POOL_LAT);

    typedef enum logic [1:0] {FEED, DRAIN, HOLD} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [DCW-1:0] dcnt;
    logic           accept;
    logic           last_accept;
    logic           load_dcnt;
    logic           capture;
    logic           clr_out;

    // in_ready is a function of state/cnt/out_ready only, never of in_valid.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            FEED:    in_ready = 1'b1;
            DRAIN:   in_ready = 1'b0;
            HOLD: begin
`ifdef POOL_CTRL_OVERLAP_EN
                in_ready = !((cnt == CNT_LAST) && out_valid && !out_ready);
`else
                in_ready = 1'b0;
`endif
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign accept      = in_valid & in_ready;
    assign last_accept = accept && (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        load_dcnt = 1'b0;
        capture   = 1'b0;
        clr_out   = 1'b0;
        case (state)
            FEED: begin
                if (last_accept) begin
                    state_nxt = DRAIN;
                    load_dcnt = 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    clr_out = 1'b1;
                    // Only reachable with overlap: the final sample goes straight to DRAIN.
                    if (last_accept) begin
                        state_nxt = DRAIN;
                        load_dcnt = 1'b1;
                    end else begin
                        state_nxt = FEED;
                    end
                end
            end
            default: state_nxt = FEED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FEED;
            cnt        <= '0;
            dcnt       <= '0;
            En         <= 1'b0;
            convResult <= '0;
            out_valid  <= 1'b0;
            out_pixels <= '0;
        end else begin
            state <= state_nxt;
            En    <= accept;
            if (accept) begin
                convResult <= in_data;
                cnt        <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            end
            if (load_dcnt) begin
                dcnt <= DCNT_INIT;
            end else if ((state == DRAIN) && (dcnt != '0)) begin
                dcnt <= dcnt - DCW'(1);
            end
            if (capture) begin
                out_pixels <= pooledPixels;
                out_valid  <= 1'b1;
            end else if (clr_out) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != FEED) || (cnt != '0);

endmodule
